// File: rtl/dco_tw_dither_pkg.sv
// Shared DCO tracking-bank constants and the tuning-word dither FSM encoding.
package dco_tw_dither_pkg;

  // Geometry of the tracking-bank cell array.
  localparam int DCO_ROWS = 5;
  localparam int DCO_COLS = 5;
  localparam int DCO_MAX  = DCO_ROWS * DCO_COLS;

  // Tracking tuning word format {int, frac} coming from the loop filter.
  localparam int TW_INT_W  = 5;
  localparam int TW_FRAC_W = 8;

  // Control FSM: wait for the first tuning word, then run forever.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dco_tw_dither_if.sv
// Tuning-word in / cell-count out bundle between the loop filter and the coder.
interface dco_tw_dither_if
  import dco_tw_dither_pkg::*;
#(
  parameter int INT_W  = TW_INT_W,
  parameter int FRAC_W = TW_FRAC_W
);

  logic                    en;
  logic                    tw_valid;
  logic [INT_W+FRAC_W-1:0] tw_in;
  logic                    dither_en;
  logic [INT_W-1:0]        word;
  logic                    word_en;
  logic                    sat;
  logic                    running;

  modport master (
    output en, tw_valid, tw_in, dither_en,
    input  word, word_en, sat, running
  );

  modport slave (
    input  en, tw_valid, tw_in, dither_en,
    output word, word_en, sat, running
  );

endinterface

// File: rtl/dco_tw_dither_mash_stage.sv
// One MASH accumulator stage: wrap-around add with carry out, synchronous clear.
module mash_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         clr,
  input  logic [W-1:0] in_val,
  output logic [W-1:0] acc_q,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] acc_d;

  // Next accumulator value; clear wins over step, otherwise hold.
  // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    {carry, sum} = {1'b0, acc_q} + {1'b0, in_val};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum;
    end
  end

  // Accumulator register.
  // NOTE: sequential state is updated with <= so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dco_tw_dither.sv
// Noise-shapes the tuning-word fraction with a 1st/2nd-order MASH and clamps
// the result to the cell array, producing the coder's word/en pair.
module dco_tw_dither
  import dco_tw_dither_pkg::*;
#(
  parameter int INT_W  = TW_INT_W,
  parameter int FRAC_W = TW_FRAC_W,
  parameter int MAX    = DCO_MAX,
  parameter int ORDER  = 2
) (
  input  logic            clk,
  input  logic            rst,
  dco_tw_dither_if.slave  bus
);

  // Two guard bits hold int + d over the full -1..+2 dither range, signed.
  typedef logic signed [INT_W+1:0] sum_t;
  localparam sum_t             MAX_S = sum_t'(MAX);
  localparam logic [INT_W-1:0] MAX_W = INT_W'(MAX);

  state_e                  state_q, state_d;
  logic [INT_W+FRAC_W-1:0] tw_q, tw_d;
  logic [INT_W-1:0]        word_q, word_d;
  logic                    word_en_q, word_en_d;
  logic                    sat_q, sat_d;
  logic                    c2_dly_q, c2_dly_d;

  logic [FRAC_W-1:0] frac;
  logic [INT_W-1:0]  int_part;
  logic [FRAC_W-1:0] acc1_q, acc2_q, sum1;
  logic              c1, c2;
  logic              mash_step, mash_clr;
  sum_t              dith, s;

  assign frac      = tw_q[FRAC_W-1:0];
  assign int_part  = tw_q[INT_W+FRAC_W-1:FRAC_W];
  assign mash_step = bus.en & (state_q == RUN) & bus.dither_en;
  assign mash_clr  = bus.en & (state_q == RUN) & ~bus.dither_en;

  mash_stage #(.W(FRAC_W)) u_stage1 (
    .clk    (clk),
    .rst    (rst),
    .step   (mash_step),
    .clr    (mash_clr),
    .in_val (frac),
    .acc_q  (acc1_q),
    .sum    (sum1),
    .carry  (c1)
  );

  // Second stage integrates the first stage's new value (acc1').
  generate
    if (ORDER == 2) begin : g_order2
      logic [FRAC_W-1:0] sum2_unused;
      mash_stage #(.W(FRAC_W)) u_stage2 (
        .clk    (clk),
        .rst    (rst),
        .step   (mash_step),
        .clr    (mash_clr),
        .in_val (sum1),
        .acc_q  (acc2_q),
        .sum    (sum2_unused),
        .carry  (c2)
      );
    end else begin : g_order1
      logic [FRAC_W-1:0] sum1_unused;
      assign sum1_unused = sum1;
      assign acc2_q      = '0;
      assign c2          = 1'b0;
    end
  endgenerate

  // Dither value d and the signed pre-clamp sum s = int + d.
  always_comb begin
    dith = '0;
    if (bus.dither_en) begin
      dith = sum_t'(c1);
      if (ORDER == 2) begin
        dith = dith + sum_t'(c2) - sum_t'(c2_dly_q);
      end
    end
    s = sum_t'(int_part) + dith;
  end

  // Next state: capture, FSM advance, clamp and strobe; en=0 freezes all but word_en.
  always_comb begin
    state_d   = state_q;
    tw_d      = tw_q;
    word_d    = word_q;
    sat_d     = sat_q;
    c2_dly_d  = c2_dly_q;
    word_en_d = 1'b0;
    if (bus.en) begin
      if (state_q == RUN) begin
        word_en_d = 1'b1;
        c2_dly_d  = bus.dither_en ? c2 : 1'b0;
        sat_d     = (s < 0) || (s > MAX_S);
        if (s < 0) begin
          word_d = '0;
        end else if (s > MAX_S) begin
          word_d = MAX_W;
        end else begin
          word_d = s[INT_W-1:0];
        end
      end
      if (bus.tw_valid) begin
        tw_d    = bus.tw_in;
        state_d = RUN;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tw_q      <= '0;
      word_q    <= '0;
      word_en_q <= 1'b0;
      sat_q     <= 1'b0;
      c2_dly_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tw_q      <= tw_d;
      word_q    <= word_d;
      word_en_q <= word_en_d;
      sat_q     <= sat_d;
      c2_dly_q  <= c2_dly_d;
    end
  end

  assign bus.word    = word_q;
  assign bus.word_en = word_en_q;
  assign bus.sat     = sat_q;
  assign bus.running = (state_q == RUN);

endmodule

// File: tb/tb_dco_tw_dither.sv
// Bench for dco_tw_dither: an ORDER=2 and an ORDER=1 instance see identical
// stimulus; each is compared every cycle against a cumulative-sum model of MASH.
module tb_dco_tw_dither;
  import dco_tw_dither_pkg::*;

  localparam int IW   = 5;
  localparam int FW   = 8;
  localparam int MAXV = 25;
  localparam int ONE  = 1 << FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dco_tw_dither_if #(.INT_W(IW), .FRAC_W(FW)) bus2 ();
  dco_tw_dither_if #(.INT_W(IW), .FRAC_W(FW)) bus1 ();

  dco_tw_dither #(.INT_W(IW), .FRAC_W(FW), .MAX(MAXV), .ORDER(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave));
  dco_tw_dither #(.INT_W(IW), .FRAC_W(FW), .MAX(MAXV), .ORDER(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model, index 0 = ORDER 2, index 1 = ORDER 1. Accumulators are kept
  // as unbounded running totals; a carry is a crossing of a multiple of 2^FW.
  bit     m_run  [2];
  int     m_int  [2];
  int     m_frac [2];
  longint m_t1   [2];
  longint m_t2   [2];
  int     m_c2p  [2];
  int     m_word [2];
  bit     m_sat  [2];
  bit     m_wen  [2];

  logic          i_en, i_tv, i_de;
  logic [IW+FW-1:0] i_tw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus2.en = i_en; bus2.tw_valid = i_tv; bus2.tw_in = i_tw; bus2.dither_en = i_de;
    bus1.en = i_en; bus1.tw_valid = i_tv; bus1.tw_in = i_tw; bus1.dither_en = i_de;
  endtask

  task automatic set_in(input bit en, input bit tv, input int ip, input int fp, input bit de);
    i_en = en; i_tv = tv; i_tw = (IW+FW)'((ip << FW) | fp); i_de = de;
    apply();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_int[i] = 0; m_frac[i] = 0; m_t1[i] = 0; m_t2[i] = 0;
      m_c2p[i] = 0; m_word[i] = 0; m_sat[i] = 0; m_wen[i] = 0;
    end
  endtask

  task automatic model_edge();
    longint n1, n2;
    int c1, c2, d, s;
    for (int i = 0; i < 2; i++) begin
      if (!i_en) begin
        m_wen[i] = 0;
      end else begin
        if (m_run[i]) begin
          d = 0;
          if (i_de) begin
            n1 = m_t1[i] + m_frac[i];
            c1 = int'(n1 / ONE - m_t1[i] / ONE);
            n2 = m_t2[i] + (n1 % ONE);
            c2 = int'(n2 / ONE - m_t2[i] / ONE);
            d  = (i == 0) ? c1 + c2 - m_c2p[i] : c1;
            m_t1[i] = n1; m_t2[i] = n2; m_c2p[i] = c2;
          end else begin
            m_t1[i] = 0; m_t2[i] = 0; m_c2p[i] = 0;
          end
          s = m_int[i] + d;
          m_word[i] = (s < 0) ? 0 : (s > MAXV) ? MAXV : s;
          m_sat[i]  = (s < 0) || (s > MAXV);
          m_wen[i]  = 1;
        end
        if (i_tv) begin
          m_int[i]  = int'(i_tw) >> FW;
          m_frac[i] = int'(i_tw) % ONE;
          m_run[i]  = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("word2",    bus2.word,    m_word[0]);
    check("sat2",     bus2.sat,     m_sat[0]);
    check("word_en2", bus2.word_en, m_wen[0]);
    check("running2", bus2.running, m_run[0]);
    check("acc1_2",   dut2.acc1_q,  int'(m_t1[0] % ONE));
    check("acc2_2",   dut2.acc2_q,  int'(m_t2[0] % ONE));
    check("word1",    bus1.word,    m_word[1]);
    check("sat1",     bus1.sat,     m_sat[1]);
    check("word_en1", bus1.word_en, m_wen[1]);
    check("running1", bus1.running, m_run[1]);
    check("acc1_1",   dut1.acc1_q,  int'(m_t1[1] % ONE));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  int sum1, sum2, bad, maxw, sat_dut, sat_mod;

  initial begin
    // Reset and idle: tw_valid absent keeps the block in IDLE.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    set_in(1, 0, 7, 3, 1);
    repeat (3) step();

    // int=12, frac=0: running right after capture, word=12 steady.
    set_in(1, 1, 12, 8'h00, 1);
    step();
    check("run_after_cap", bus2.running, 1);
    set_in(1, 0, 0, 0, 1);
    repeat (12) step();
    check("w12_const", bus2.word, 12);

    // int=12, frac=0x80: ORDER 1 alternates 12/13, exact mean over 256 cycles.
    set_in(1, 1, 12, 8'h80, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    sum1 = 0;
    for (int k = 0; k < ONE; k++) begin
      step();
      sum1 += int'(bus1.word);
    end
    check("ord1_sum", sum1, 3200);

    // int=10, frac=0x40, ORDER 2: words in 9..12, sum within 1 of 2624.
    set_in(1, 1, 10, 8'h40, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    sum2 = 0; bad = 0;
    for (int k = 0; k < ONE; k++) begin
      step();
      sum2 += int'(bus2.word);
      if (bus2.word < 9 || bus2.word > 12) bad++;
    end
    check("ord2_range", bad, 0);
    check("ord2_sum_in_band", (sum2 >= 2623 && sum2 <= 2625), 1);

    // dither_en=0: plain int, accumulators cleared.
    set_in(1, 0, 0, 0, 0);
    repeat (6) step();
    check("nodith_word", bus2.word, 10);
    check("nodith_acc1", dut2.acc1_q, 0);
    check("nodith_acc2", dut2.acc2_q, 0);

    // en low for 3 cycles mid-run: frozen, word_en=0.
    set_in(1, 0, 0, 0, 1);
    repeat (7) step();
    set_in(0, 1, 3, 8'h11, 1);
    repeat (3) begin
      step();
      check("en_low_wen", bus2.word_en, 0);
    end
    set_in(1, 0, 0, 0, 1);
    repeat (3) step();

    // int=25, frac=0xFF: clamp at MAX with sat on clamped cycles.
    set_in(1, 1, 25, 8'hFF, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    maxw = 0; sat_dut = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (int'(bus2.word) > maxw) maxw = int'(bus2.word);
      if (bus2.sat) sat_dut++;
    end
    check("hi_max_le_25", (maxw <= MAXV), 1);
    check("hi_sat_seen", (sat_dut > 0), 1);

    // int=31: word=MAX, sat steady regardless of dither.
    set_in(1, 1, 31, 8'h9C, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    repeat (20) step();
    check("int31_word", bus2.word, MAXV);
    check("int31_sat", bus2.sat, 1);

    // int=0, frac=0x01: d=-1 clamps to 0 with sat pulses.
    set_in(1, 1, 0, 8'h01, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    sat_dut = 0; sat_mod = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (bus2.sat) sat_dut++;
      if (m_sat[0]) sat_mod++;
    end
    check("lo_sat_count", sat_dut, sat_mod);
    check("lo_sat_seen", (sat_dut > 0), 1);

    // Asynchronous reset mid-run, then IDLE until the next tw_valid.
    set_in(1, 1, 14, 8'h37, 1);
    repeat (5) step();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("rst_word", bus2.word, 0);
    check("rst_running", bus2.running, 0);
    set_in(1, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    repeat (4) step();
    check("post_rst_idle", bus2.running, 0);
    set_in(1, 1, 14, 8'h37, 1);
    step();
    set_in(1, 0, 0, 0, 1);
    repeat (3) step();

    // Randomised traffic against the model.
    for (int k = 0; k < 800; k++) begin
      set_in(($urandom % 8) != 0, ($urandom % 16) == 0,
             int'($urandom % 32), int'($urandom % 256), ($urandom % 10) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
